// File: rtl/rv32i_defs_pkg.sv
// Shared RV32I constants for the front end: word width, bubble encoding,
// reset PC and the register-source field positions the hazard unit compares.
package rv32i_defs;

    localparam int XLEN = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load-enable with a flush that outranks the enable.
// Reset and flush both leave a bubble (NOP, valid=0, zero PCs) in the slot.
module ifid_reg
    import rv32i_defs::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            en,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    input  logic [XLEN-1:0] d_instr,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_pc_plus4,
    output logic [XLEN-1:0] q_instr,
    output logic            q_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            q_pc       <= '0;
            q_pc_plus4 <= '0;
            q_instr    <= BUBBLE_INSTR;
            q_valid    <= 1'b0;
        end else if (en) begin
            q_pc       <= d_pc;
            q_pc_plus4 <= d_pc_plus4;
            q_instr    <= d_instr;
            q_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, next-PC selection and the IF/ID register.
// Every output comes straight from a flop, so stall/redirect inputs only act at the edge.
module fetch_stage
    import rv32i_defs::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = rv32i_defs::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pc_write,
    input  logic                  ifid_write,
    input  logic                  branch_taken,
    input  logic [XLEN-1:0]       branch_target,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [XLEN-1:0]       imem_rdata,
    output logic [XLEN-1:0]       ifid_pc,
    output logic [XLEN-1:0]       ifid_pc_plus4,
    output logic [XLEN-1:0]       ifid_instr,
    output logic                  ifid_valid,
    output logic [REG_ADDR_W-1:0] ifid_rs1,
    output logic [REG_ADDR_W-1:0] ifid_rs2
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;

    assign pc_plus4       = pc + INSTR_BYTES;
    // Low target bits are dropped silently; there is no misaligned-fetch trap.
    assign target_aligned = branch_target & ~32'h0000_0003;

    // Redirect wins over a hazard stall: the stalled instruction is on the wrong path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= target_aligned;
        end else if (pc_write) begin
            pc <= pc_plus4;
        end
    end

    assign imem_addr = pc;

    ifid_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (branch_taken),
        .en         (ifid_write),
        .d_pc       (pc),
        .d_pc_plus4 (pc_plus4),
        .d_instr    (imem_rdata),
        .q_pc       (ifid_pc),
        .q_pc_plus4 (ifid_pc_plus4),
        .q_instr    (ifid_instr),
        .q_valid    (ifid_valid)
    );

    assign ifid_rs1 = ifid_instr[RS1_LSB +: REG_ADDR_W];
    assign ifid_rs2 = ifid_instr[RS2_LSB +: REG_ADDR_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-level model of the fetch rules checked
// every cycle, plus literal expectations at each scenario point.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [31:0] imem_addr, imem_rdata, ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        ifid_valid;
    logic [4:0]  ifid_rs1, ifid_rs2;

    logic [31:0] w_imem_addr, w_imem_rdata, w_ifid_pc, w_ifid_pc_plus4, w_ifid_instr;
    logic        w_ifid_valid;
    logic [4:0]  w_ifid_rs1, w_ifid_rs2;

    int checks = 0;
    int errors = 0;

    // Program image shared by both instances.
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            32'h0000_0008: return 32'h0020_81B3;
            32'h0000_000C: return 32'h0030_8233;
            32'h0000_0010: return 32'h0041_02B3;
            32'h0000_0100: return 32'h0010_0513;
            32'h0000_0104: return 32'h0020_0593;
            32'hFFFF_FFFC: return 32'h0031_0633;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    assign imem_rdata   = imem(imem_addr);
    assign w_imem_rdata = imem(w_imem_addr);

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (w_imem_addr),
        .imem_rdata    (w_imem_rdata),
        .ifid_pc       (w_ifid_pc),
        .ifid_pc_plus4 (w_ifid_pc_plus4),
        .ifid_instr    (w_ifid_instr),
        .ifid_valid    (w_ifid_valid),
        .ifid_rs1      (w_ifid_rs1),
        .ifid_rs2      (w_ifid_rs2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    // The stage as a machine: a PC and a one-deep fetched slot.
    logic [31:0] m_pc, m_slot_pc, m_slot_instr;
    logic        m_slot_valid;
    logic        m_known = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc         <= 32'h0;
            m_slot_pc    <= 32'h0;
            m_slot_instr <= 32'h13;
            m_slot_valid <= 1'b0;
            m_known      <= 1'b1;
        end else if (branch_taken) begin
            m_pc         <= {branch_target[31:2], 2'b00};
            m_slot_pc    <= 32'h0;
            m_slot_instr <= 32'h13;
            m_slot_valid <= 1'b0;
        end else begin
            if (pc_write) m_pc <= m_pc + 32'd4;
            if (ifid_write) begin
                m_slot_pc    <= m_pc;
                m_slot_instr <= imem(m_pc);
                m_slot_valid <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_known) begin
            check("m_imem_addr", imem_addr, m_pc);
            check("m_ifid_pc", ifid_pc, m_slot_valid ? m_slot_pc : 32'h0);
            check("m_ifid_pc_plus4", ifid_pc_plus4, m_slot_valid ? m_slot_pc + 32'd4 : 32'h0);
            check("m_ifid_instr", ifid_instr, m_slot_instr);
            check("m_ifid_valid", {31'h0, ifid_valid}, {31'h0, m_slot_valid});
            check("m_ifid_rs1", {27'h0, ifid_rs1}, {27'h0, m_slot_instr[19:15]});
            check("m_ifid_rs2", {27'h0, ifid_rs2}, {27'h0, m_slot_instr[24:20]});
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic bt, input logic [31:0] tgt);
        rst_n         = r;
        pc_write      = pw;
        ifid_write    = iw;
        branch_taken  = bt;
        branch_target = tgt;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1;
        branch_taken = 1'b0; branch_target = 32'h0;

        // Reset held two cycles, then released: reset values visible before the first free edge.
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_ifid_instr", ifid_instr, 32'h0000_0013);
        check("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
        check("rst_ifid_pc", ifid_pc, 32'h0);
        check("rst_wrap_imem_addr", w_imem_addr, 32'hFFFF_FFFC);

        // Streaming, first free edge; wrap instance crosses 2^32.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("s1_imem_addr", imem_addr, 32'h4);
        check("s1_ifid_pc", ifid_pc, 32'h0);
        check("s1_ifid_instr", ifid_instr, 32'h0050_0093);
        check("s1_ifid_valid", {31'h0, ifid_valid}, 32'h1);
        check("wrap_imem_addr", w_imem_addr, 32'h0);
        check("wrap_ifid_pc", w_ifid_pc, 32'hFFFF_FFFC);
        check("wrap_ifid_pc_plus4", w_ifid_pc_plus4, 32'h0);
        check("wrap_ifid_instr", w_ifid_instr, 32'h0031_0633);

        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("s2_imem_addr", imem_addr, 32'h8);
        check("s2_ifid_pc", ifid_pc, 32'h4);
        check("s2_ifid_instr", ifid_instr, 32'h00A0_0113);

        // Load-use stall at pc=8.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_imem_addr", imem_addr, 32'h8);
        check("stall_ifid_pc", ifid_pc, 32'h4);
        check("stall_ifid_instr", ifid_instr, 32'h00A0_0113);

        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("resume_imem_addr", imem_addr, 32'hC);
        check("resume_ifid_pc", ifid_pc, 32'h8);
        check("resume_ifid_pc_plus4", ifid_pc_plus4, 32'hC);
        check("resume_ifid_instr", ifid_instr, 32'h0020_81B3);
        check("resume_rs1", {27'h0, ifid_rs1}, 32'h1);
        check("resume_rs2", {27'h0, ifid_rs2}, 32'h2);

        // PC advances while IF/ID holds.
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check("split_imem_addr", imem_addr, 32'h10);
        check("split_ifid_pc", ifid_pc, 32'h8);

        // Redirect beats a stall; target low bits dropped.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103);
        check("redir_imem_addr", imem_addr, 32'h100);
        check("redir_ifid_instr", ifid_instr, 32'h0000_0013);
        check("redir_ifid_valid", {31'h0, ifid_valid}, 32'h0);
        check("redir_rs1", {27'h0, ifid_rs1}, 32'h0);
        check("redir_rs2", {27'h0, ifid_rs2}, 32'h0);

        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("tgt_imem_addr", imem_addr, 32'h104);
        check("tgt_ifid_pc", ifid_pc, 32'h100);
        check("tgt_ifid_instr", ifid_instr, 32'h0010_0513);
        check("tgt_ifid_valid", {31'h0, ifid_valid}, 32'h1);

        // Reset in the same cycle as a redirect: reset wins.
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
        check("rstbr_imem_addr", imem_addr, 32'h0);
        check("rstbr_ifid_instr", ifid_instr, 32'h0000_0013);
        check("rstbr_ifid_valid", {31'h0, ifid_valid}, 32'h0);
        check("rstbr_ifid_pc_plus4", ifid_pc_plus4, 32'h0);

        // A few more free-running cycles under the model.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        end
        check("tail_imem_addr", imem_addr, 32'h10);
        check("tail_ifid_instr", ifid_instr, 32'h0030_8233);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
